acc_param: RTL
==============

ACC_PARAM -- requirements
Module: acc_param

Interface
REQ-001 SHALL have parameter NB_DATA, default 3, operand width in bits.
REQ-002 SHALL have parameter NB_ACC, default 6, accumulator width in bits (NB_ACC > NB_DATA).
REQ-003 SHALL have parameter NB_CNT, default 4, block-length counter width.
REQ-004 SHALL have parameter SIGNED, default 0; 0 = unsigned two's-complement-free arithmetic, 1 = signed two's complement.
REQ-005 SHALL have parameter SATURATE, default 0; 0 = wrap on overflow, 1 = clamp on overflow.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port i_valid  input  1  sample strobe; operands accepted when high.
REQ-009 SHALL have port i_clear  input  1  synchronous soft clear.
REQ-010 SHALL have port i_sel  input  2  mode: 00 add i_data1, 01 add i_data2, 10 add i_data1+i_data2, 11 hold.
REQ-011 SHALL have ports i_data1, i_data2  input  NB_DATA  operands.
REQ-012 SHALL have port i_dump_len  input  NB_CNT  samples per block; 0 = free-running, no dump.
REQ-013 SHALL have port o_data  output  NB_ACC  registered accumulator value.
REQ-014 SHALL have port o_carry  output  1  registered overflow of the most recent accepted add.
REQ-015 SHALL have port o_ovf_sticky  output  1  OR of all o_carry events since last reset/clear.
REQ-016 SHALL have port o_valid  output  1  one-cycle pulse marking block completion.

Function
REQ-017 SHALL accept a sample on a rising edge where i_valid=1, i_clear=0 and i_sel!=11; i_sel=11 samples are ignored (no add, not counted).
REQ-018 SHALL extend operands to NB_ACC+1 bits (zero-extend when SIGNED=0, sign-extend when SIGNED=1) before any addition; mode 10 sums both operands first.
REQ-019 SHALL update o_data one cycle after acceptance (latency 1); o_data holds when no sample is accepted.
REQ-020 SHALL set o_carry, when SIGNED=0, to bit NB_ACC of the extended sum; when SIGNED=1, to signed overflow (result sign differs from both-equal operand signs); o_carry SHALL clear on the next accepted sample without overflow and hold otherwise.
REQ-021 SHALL, with SATURATE=0, keep the low NB_ACC bits (wrap-around); with SATURATE=1, clamp to max (2^NB_ACC-1 unsigned, 2^(NB_ACC-1)-1 signed) or signed min on overflow; o_carry asserts in both cases.
REQ-022 SHALL implement states IDLE (accumulator zero, count zero), RUN (accumulating), DUMP (block complete).
REQ-023 SHALL transition IDLE->RUN on first accepted sample, loading o_data = 0 + operand.
REQ-024 SHALL, when i_dump_len!=0 and the accepted-sample count reaches i_dump_len, go RUN->DUMP, pulse o_valid for exactly one cycle with o_data equal to the block's final sum.
REQ-025 SHALL leave DUMP after one cycle: to RUN loading the new operand if a sample is accepted in that cycle, else to IDLE with o_data held at the block result until the next accepted sample restarts from zero.
REQ-026 SHALL, with i_dump_len=0, never assert o_valid and never restart the accumulator.
REQ-027 SHALL give i_clear priority over i_valid: accumulator, count, o_carry, o_ovf_sticky, o_valid all zero, state IDLE, concurrent sample dropped.
REQ-028 SHALL sample i_dump_len at each accepted sample; lowering it below the current count completes the block on that sample.

Reset
REQ-029 SHALL, on i_rst=1 at a rising edge, force o_data=0, o_carry=0, o_ovf_sticky=0, o_valid=0, count=0, state IDLE, with priority over i_clear and i_valid, including mid-block.

Verification
REQ-030 Defaults, i_data1=1, i_data2=2, i_dump_len=0: 5 samples sel=00 -> o_data=5; clear; 3 samples sel=01 -> 6; clear; 10 samples sel=10 -> 30, o_carry=0.
REQ-031 Defaults, sel=10, data 1/2, 22 samples -> after 21st o_data=63, after 22nd o_data=2, o_carry=1, o_ovf_sticky=1; 23rd -> 5, o_carry=0, sticky=1.
REQ-032 SATURATE=1, same stimulus -> o_data stays 63 from sample 22 on, o_carry=1.
REQ-033 i_dump_len=4, sel=00, i_data1=3, continuous valid -> o_valid single pulse with o_data=12 after 4th sample, 5th sample gives o_data=3; sel=11 interleaved does not advance count.
REQ-034 SIGNED=1, i_data1=3'b111, sel=00, 3 samples -> o_data=6'b111101 (-3), o_carry=0.
REQ-035 i_rst=1 asserted mid-block with i_valid and i_clear high -> next cycle all outputs 0, state IDLE; i_clear with i_valid -> sample dropped, o_data=0.

Source files
------------

// File: rtl/acc_param.sv
// Parameterised block accumulator with wrap/saturate and signed/unsigned modes.
// Emits a one-cycle o_valid pulse with the block sum every i_dump_len samples.
module acc_param #(
  parameter int NB_DATA  = 3,
  parameter int NB_ACC   = 6,
  parameter int NB_CNT   = 4,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_clear,
  input  logic [1:0]        i_sel,
  input  logic [NB_DATA-1:0] i_data1,
  input  logic [NB_DATA-1:0] i_data2,
  input  logic [NB_CNT-1:0] i_dump_len,
  output logic [NB_ACC-1:0] o_data,
  output logic              o_carry,
  output logic              o_ovf_sticky,
  output logic              o_valid
);

  localparam int NE = NB_ACC + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DUMP
  } state_t;

  state_t            state;
  logic [NB_CNT-1:0] cnt;

  logic              accept;
  logic [NE-1:0]     opnd;
  logic [NE-1:0]     base;
  logic [NE-1:0]     sum;
  logic              ovf;
  logic              neg;
  logic [NB_ACC-1:0] res;
  logic [NB_CNT-1:0] cnt_nxt;
  logic              done;

  function automatic logic [NE-1:0] ext(
    input logic [NB_DATA-1:0] d
  );
    logic fill;
    fill = (SIGNED != 0) & d[NB_DATA-1];
    return {{(NE-NB_DATA){fill}}, d};
  endfunction

  // Operand select, extended add, overflow detect and clamp.
  always_comb begin
    opnd = '0;
    unique case (i_sel)
      2'b00:   opnd = ext(i_data1);
      2'b01:   opnd = ext(i_data2);
      2'b10:   opnd = ext(i_data1) + ext(i_data2);
      default: opnd = '0;
    endcase

    // Only a running block builds on the old sum; a new
    // block always starts from zero.
    base = '0;
    if (state == RUN) begin
      base = {(SIGNED != 0) & o_data[NB_ACC-1], o_data};
    end

    sum = base + opnd;

    if (SIGNED != 0) begin
      ovf = (base[NB_ACC-1] == opnd[NB_ACC-1]) &&
            (sum[NB_ACC-1] != base[NB_ACC-1]);
      neg = base[NB_ACC-1];
    end else begin
      ovf = sum[NB_ACC];
      neg = 1'b0;
    end

    res = sum[NB_ACC-1:0];
    if ((SATURATE != 0) && ovf) begin
      if (SIGNED != 0) begin
        res = neg ? {1'b1, {(NB_ACC-1){1'b0}}}
                  : {1'b0, {(NB_ACC-1){1'b1}}};
      end else begin
        res = '1;
      end
    end

    accept = i_valid & ~i_clear & (i_sel != 2'b11);

    // Count saturates so a long free-run never wraps back
    // below a later-programmed block length.
    if (state == RUN) begin
      cnt_nxt = (cnt == '1) ? cnt : cnt + NB_CNT'(1);
    end else begin
      cnt_nxt = NB_CNT'(1);
    end

    done = (i_dump_len != '0) && (cnt_nxt >= i_dump_len);
  end

  // State, accumulator, flags and block-complete pulse.
  always_ff @(posedge clk) begin
    if (i_rst || i_clear) begin
      state        <= IDLE;
      cnt          <= '0;
      o_data       <= '0;
      o_carry      <= 1'b0;
      o_ovf_sticky <= 1'b0;
      o_valid      <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (accept) begin
        o_data       <= res;
        o_carry      <= ovf;
        o_ovf_sticky <= o_ovf_sticky | ovf;
        cnt          <= cnt_nxt;
        if (done) begin
          state   <= DUMP;
          o_valid <= 1'b1;
        end else begin
          state <= RUN;
        end
      end else if (state == DUMP) begin
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end

endmodule
